// File: rtl/multdiv_ctrl_pkg.sv
// Shared constants, state type and helpers for the multiply/divide sequencer.
package multdiv_ctrl_pkg;

  localparam logic [4:0] OP_ALU      = 5'd0;
  localparam logic [4:0] ALUOP_MUL   = 5'd6;
  localparam logic [4:0] ALUOP_DIV   = 5'd7;
  localparam logic [4:0] REG_RSTATUS = 5'd30;

  // Must match the codes expected by the rstatus exception select.
  localparam logic [2:0] EXC_MUL = 3'd4;
  localparam logic [2:0] EXC_DIV = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_BUSY,
    ST_DONE
  } md_state_e;

  function automatic logic is_md_op(input logic [4:0] opcode, input logic [4:0] aluop);
    return (opcode == OP_ALU) && ((aluop == ALUOP_MUL) || (aluop == ALUOP_DIV));
  endfunction

  function automatic logic [31:0] exc_word(input logic is_div);
    return {29'd0, (is_div ? EXC_DIV : EXC_MUL)};
  endfunction

endpackage

// File: rtl/multdiv_ctrl_md_watchdog.sv
// Busy-cycle counter with synchronous clear/enable and a terminal-count flag.
module md_watchdog #(
  parameter int unsigned MAX_CYCLES = 40,
  parameter int unsigned CNT_W      = 6
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == CNT_W'(MAX_CYCLES - 1));

endmodule

// File: rtl/multdiv_ctrl.sv
// Sequencer for the shared multi-cycle mul/div unit: start strobe, pipeline
// stall, watchdog, and a single writeback to rd or $rstatus.
module multdiv_ctrl
  import multdiv_ctrl_pkg::*;
#(
  parameter int unsigned MAX_CYCLES = 40,
  parameter int unsigned CNT_W      = 6
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        x_valid,
  input  logic [4:0]  x_opcode,
  input  logic [4:0]  x_aluop,
  input  logic [4:0]  x_rd,
  input  logic        flush,
  input  logic        md_rdy,
  input  logic        md_exc,
  input  logic [31:0] md_result,
  output logic        ctrl_mult,
  output logic        ctrl_div,
  output logic        stall,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        timeout
);

  md_state_e   state_q, state_d;
  logic [4:0]  rd_q, rd_d;
  logic        div_q, div_d;
  logic [31:0] res_q, res_d;
  logic        exc_q, exc_d;
  logic        tmo_q, tmo_d;
  logic        mult_q, mult_d;
  logic        dstb_q, dstb_d;
  logic        wd_clr, wd_en, wd_tc;
  logic        go;

  // Gated by reset so stall reads as its reset value while reset is held.
  assign go = reset & x_valid & is_md_op(x_opcode, x_aluop) & ~flush;

  md_watchdog #(
    .MAX_CYCLES (MAX_CYCLES),
    .CNT_W      (CNT_W)
  ) u_watchdog (
    .clk_i  (clock),
    .rst_ni (reset),
    .clr_i  (wd_clr),
    .en_i   (wd_en),
    .tc_o   (wd_tc)
  );

  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    div_d   = div_q;
    res_d   = res_q;
    exc_d   = exc_q;
    tmo_d   = tmo_q;
    mult_d  = 1'b0;
    dstb_d  = 1'b0;
    wd_clr  = 1'b0;
    wd_en   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (go) begin
          rd_d    = x_rd;
          div_d   = (x_aluop == ALUOP_DIV);
          mult_d  = (x_aluop != ALUOP_DIV);
          dstb_d  = (x_aluop == ALUOP_DIV);
          state_d = ST_START;
        end
      end
      ST_START: begin
        wd_clr  = 1'b1;
        state_d = ST_BUSY;
      end
      ST_BUSY: begin
        wd_en = 1'b1;
        // md_rdy takes priority over a coincident watchdog expiry.
        if (md_rdy) begin
          res_d   = md_result;
          exc_d   = md_exc;
          state_d = ST_DONE;
        end else if (wd_tc) begin
          tmo_d   = 1'b1;
          exc_d   = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (flush && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      tmo_d   = tmo_q;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      rd_q    <= '0;
      div_q   <= 1'b0;
      res_q   <= '0;
      exc_q   <= 1'b0;
      tmo_q   <= 1'b0;
      mult_q  <= 1'b0;
      dstb_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      div_q   <= div_d;
      res_q   <= res_d;
      exc_q   <= exc_d;
      tmo_q   <= tmo_d;
      mult_q  <= mult_d;
      dstb_q  <= dstb_d;
    end
  end

  assign ctrl_mult = mult_q;
  assign ctrl_div  = dstb_q;
  assign timeout   = tmo_q;

  assign stall = ((state_q == ST_IDLE) & go) | (state_q == ST_START) | (state_q == ST_BUSY);

  always_comb begin
    wb_valid = 1'b0;
    wb_rd    = '0;
    wb_data  = '0;
    if (state_q == ST_DONE) begin
      if (exc_q) begin
        wb_valid = ~flush;
        wb_rd    = REG_RSTATUS;
        wb_data  = exc_word(div_q);
      end else begin
        wb_valid = ~flush & (rd_q != 5'd0);
        wb_rd    = rd_q;
        wb_data  = res_q;
      end
    end
  end

endmodule
